// File: rtl/mem_ctrl.sv
// Single-outstanding load/store engine: latches one issued memory op, runs it on
// the SRAM-like d-bus and returns lane-extracted, extended load data to commit.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              mem_issued_i,
  input  logic [ADDR_W-1:0] op_addr_i,
  input  logic [DATA_W-1:0] op_wdata_i,
  input  logic [1:0]        op_size_i,
  input  logic              op_store_i,
  input  logic              op_signed_i,
  input  logic [TAG_W-1:0]  op_tag_i,
  input  logic              flush_i,
  output logic              wait_mem_o,
  output logic              d_req_o,
  output logic              d_wr_o,
  output logic [1:0]        d_size_o,
  output logic [ADDR_W-1:0] d_addr_o,
  output logic [DATA_W-1:0] d_wdata_o,
  input  logic              d_addr_ok_i,
  input  logic              d_data_ok_i,
  input  logic [DATA_W-1:0] d_rdata_i,
  output logic              res_valid_o,
  output logic [TAG_W-1:0]  res_tag_o,
  output logic [DATA_W-1:0] res_data_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e            state_q, state_d;
  logic              latch_en;
  logic              wait_q, req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q;
  logic              store_q, signed_q;
  logic [TAG_W-1:0]  tag_q;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DATA_W-1:0] load_data;

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    case (state_q)
      IDLE: if (mem_issued_i && !flush_i) begin
        latch_en = 1'b1;
        state_d  = REQ;
      end
      // An accepted request must still see its data_ok, hence DROP on flush.
      REQ: begin
        if (d_addr_ok_i)  state_d = flush_i ? DROP : WAIT;
        else if (flush_i) state_d = IDLE;
      end
      WAIT: begin
        if (flush_i)          state_d = d_data_ok_i ? IDLE : DROP;
        else if (d_data_ok_i) state_d = IDLE;
      end
      DROP: if (d_data_ok_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Store data is lane-replicated once at latch time so the bus sees it stable.
  always_comb begin
    case (op_size_i)
      2'b00:   wdata_d = {(DATA_W/8){op_wdata_i[7:0]}};
      2'b01:   wdata_d = {(DATA_W/16){op_wdata_i[15:0]}};
      default: wdata_d = op_wdata_i;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = d_rdata_i[7:0];
      2'd1:    lane_b = d_rdata_i[15:8];
      2'd2:    lane_b = d_rdata_i[23:16];
      default: lane_b = d_rdata_i[31:24];
    endcase
    lane_h = addr_q[1] ? d_rdata_i[31:16] : d_rdata_i[15:0];
    case (size_q)
      2'b00:   load_data = {{(DATA_W-8){signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{(DATA_W-16){signed_q & lane_h[15]}}, lane_h};
      default: load_data = d_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      wait_q   <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= (state_d != IDLE);
      req_q   <= (state_d == REQ);
      if (latch_en) begin
        addr_q   <= op_addr_i;
        wdata_q  <= wdata_d;
        size_q   <= op_size_i;
        store_q  <= op_store_i;
        signed_q <= op_signed_i;
        tag_q    <= op_tag_i;
      end
    end
  end

  assign wait_mem_o  = wait_q;
  assign d_req_o     = req_q;
  assign d_wr_o      = store_q;
  assign d_size_o    = size_q;
  assign d_addr_o    = addr_q;
  assign d_wdata_o   = wdata_q;
  assign res_valid_o = (state_q == WAIT) && d_data_ok_i && !flush_i;
  assign res_tag_o   = tag_q;
  assign res_data_o  = (res_valid_o && !store_q) ? load_data : '0;

  // Protocol checks: issue only when idle, data_ok only while a request is outstanding.
  assert property (@(posedge clk_i) disable iff (reset_i)
    !(mem_issued_i && state_q != IDLE));
  assert property (@(posedge clk_i) disable iff (reset_i)
    !(d_data_ok_i && !(state_q == WAIT || state_q == DROP)));

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl: a transaction-level script sets the expected
// outputs for every cycle and one negedge process compares the DUT against them.
module tb_mem_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        mem_issued_i;
  logic [31:0] op_addr_i;
  logic [31:0] op_wdata_i;
  logic [1:0]  op_size_i;
  logic        op_store_i;
  logic        op_signed_i;
  logic [5:0]  op_tag_i;
  logic        flush_i;
  logic        wait_mem_o;
  logic        d_req_o;
  logic        d_wr_o;
  logic [1:0]  d_size_o;
  logic [31:0] d_addr_o;
  logic [31:0] d_wdata_o;
  logic        d_addr_ok_i;
  logic        d_data_ok_i;
  logic [31:0] d_rdata_i;
  logic        res_valid_o;
  logic [5:0]  res_tag_o;
  logic [31:0] res_data_o;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TAG_W(6)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .mem_issued_i(mem_issued_i),
    .op_addr_i(op_addr_i), .op_wdata_i(op_wdata_i), .op_size_i(op_size_i),
    .op_store_i(op_store_i), .op_signed_i(op_signed_i), .op_tag_i(op_tag_i),
    .flush_i(flush_i), .wait_mem_o(wait_mem_o), .d_req_o(d_req_o),
    .d_wr_o(d_wr_o), .d_size_o(d_size_o), .d_addr_o(d_addr_o),
    .d_wdata_o(d_wdata_o), .d_addr_ok_i(d_addr_ok_i), .d_data_ok_i(d_data_ok_i),
    .d_rdata_i(d_rdata_i), .res_valid_o(res_valid_o), .res_tag_o(res_tag_o),
    .res_data_o(res_data_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int expCount = 0;
  int resCount = 0;

  // Per-cycle expectations written by the stimulus script.
  logic        chkEn = 1'b0;
  logic        expWait, expReq, expValid, expRes, expD;
  logic [5:0]  expTag;
  logic [31:0] expData;
  logic        expWr;
  logic [1:0]  expSize;
  logic [31:0] expAddr, expWdata;

  logic [31:0] lastData;
  logic [5:0]  lastTag;
  logic [31:0] lastDWdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] extractLoad(input logic [31:0] rd, input logic [31:0] ad,
                                              input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    case (sz)
      2'b00: begin
        v = (rd >> (8 * ad[1:0])) & 32'hFF;
        if (sg && v >= 32'd128) v = v - 32'd256;
      end
      2'b01: begin
        v = (rd >> (16 * ad[1])) & 32'hFFFF;
        if (sg && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] replicateStore(input logic [31:0] wd, input logic [1:0] sz);
    case (sz)
      2'b00:   return (wd & 32'hFF) * 32'h01010101;
      2'b01:   return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  always @(negedge clk_i) begin
    if (chkEn) begin
      checkOutput("wait_mem", {31'd0, wait_mem_o}, {31'd0, expWait});
      checkOutput("d_req", {31'd0, d_req_o}, {31'd0, expReq});
      checkOutput("res_valid", {31'd0, res_valid_o}, {31'd0, expValid});
      if (expRes) begin
        checkOutput("res_tag", {26'd0, res_tag_o}, {26'd0, expTag});
        checkOutput("res_data", res_data_o, expData);
      end
      if (expD) begin
        checkOutput("d_wr", {31'd0, d_wr_o}, {31'd0, expWr});
        checkOutput("d_size", {30'd0, d_size_o}, {30'd0, expSize});
        checkOutput("d_addr", d_addr_o, expAddr);
        checkOutput("d_wdata", d_wdata_o, expWdata);
      end
    end
    if (res_valid_o) begin
      resCount++;
      lastData = res_data_o;
      lastTag  = res_tag_o;
    end
    if (d_req_o) lastDWdata = d_wdata_o;
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clearExp();
    expWait = 1'b0; expReq = 1'b0; expValid = 1'b0; expRes = 1'b0; expD = 1'b0;
    expTag = '0; expData = '0; expWr = 1'b0; expSize = '0; expAddr = '0; expWdata = '0;
  endtask

  task automatic idleCycle();
    mem_issued_i = 1'b0; d_addr_ok_i = 1'b0; d_data_ok_i = 1'b0;
    flush_i = 1'($urandom_range(0, 1));
    clearExp();
    cycle();
    flush_i = 1'b0;
  endtask

  // mode: 0 normal, 1 flush in REQ without addr_ok, 2 flush with addr_ok,
  // 3 flush at first WAIT cycle, 4 flush together with data_ok, 5 flush on issue.
  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic sg,
                               input logic [31:0] ad, input logic [31:0] wd, input logic [5:0] tg,
                               input logic [31:0] rd, input int aDly, input int dDly, input int mode);
    logic [31:0] wExp, rExp;
    logic dropped;
    wExp = replicateStore(wd, sz);
    rExp = st ? 32'd0 : extractLoad(rd, ad, sz, sg);
    mem_issued_i = 1'b1; op_store_i = st; op_size_i = sz; op_signed_i = sg;
    op_addr_i = ad; op_wdata_i = wd; op_tag_i = tg;
    flush_i = (mode == 5); d_addr_ok_i = 1'b0; d_data_ok_i = 1'b0;
    clearExp();
    cycle();
    mem_issued_i = 1'b0; op_addr_i = $urandom; op_wdata_i = $urandom; op_tag_i = 6'($urandom);
    op_size_i = 2'($urandom_range(0, 2)); op_store_i = 1'($urandom); op_signed_i = 1'($urandom);
    flush_i = 1'b0;
    if (mode == 5) return;
    for (int k = 0; k <= aDly; k++) begin
      d_addr_ok_i = (k == aDly) && (mode != 1);
      flush_i = (k == aDly) && (mode == 1 || mode == 2);
      d_rdata_i = $urandom;
      expWait = 1'b1; expReq = 1'b1; expD = 1'b1;
      expWr = st; expSize = sz; expAddr = ad; expWdata = wExp;
      cycle();
    end
    d_addr_ok_i = 1'b0; flush_i = 1'b0; expReq = 1'b0; expD = 1'b0;
    if (mode == 1) return;
    dropped = (mode == 2);
    for (int k = 0; k <= dDly; k++) begin
      d_data_ok_i = (k == dDly);
      d_rdata_i = (k == dDly) ? rd : $urandom;
      if (mode == 3 && k == 0)           flush_i = 1'b1;
      else if (mode == 4 && k == dDly)   flush_i = 1'b1;
      else if (dropped)                  flush_i = 1'($urandom_range(0, 1));
      else                               flush_i = 1'b0;
      expWait = 1'b1;
      expValid = (k == dDly) && !dropped && !flush_i;
      expRes = expValid; expTag = tg; expData = rExp;
      if (expValid) expCount++;
      cycle();
      if (flush_i) dropped = 1'b1;
    end
    d_data_ok_i = 1'b0; flush_i = 1'b0; expValid = 1'b0; expRes = 1'b0;
  endtask

  task automatic checkResetState();
    clearExp();
    expRes = 1'b1; expD = 1'b1;
    mem_issued_i = 1'b0; flush_i = 1'b0; d_addr_ok_i = 1'b0; d_data_ok_i = 1'b0;
    cycle();
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] ad;
    int r, mode, dDly;
    reset_i = 1'b1; mem_issued_i = 1'b0; op_addr_i = '0; op_wdata_i = '0; op_size_i = '0;
    op_store_i = 1'b0; op_signed_i = 1'b0; op_tag_i = '0; flush_i = 1'b0;
    d_addr_ok_i = 1'b0; d_data_ok_i = 1'b0; d_rdata_i = '0;
    clearExp();
    cycle(); cycle();
    reset_i = 1'b0;
    chkEn = 1'b1;
    checkResetState();

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h80001004, 32'h0, 6'h15, 32'hDEADBEEF, 0, 0, 0);
    checkOutput("lw_data", lastData, 32'hDEADBEEF);
    checkOutput("lw_tag", {26'd0, lastTag}, 32'h15);
    idleCycle();
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h80001003, 32'h0, 6'h01, 32'h80FF7F01, 1, 2, 0);
    checkOutput("lb_data", lastData, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h80001003, 32'h0, 6'h02, 32'h80FF7F01, 0, 1, 0);
    checkOutput("lbu_data", lastData, 32'h00000080);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h80001002, 32'h0, 6'h03, 32'h80FF7F01, 2, 0, 0);
    checkOutput("lh_data", lastData, 32'hFFFF80FF);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h80002002, 32'h1234ABCD, 6'h04, 32'h0, 3, 1, 0);
    checkOutput("sh_wdata", lastDWdata, 32'hABCDABCD);
    checkOutput("sh_data", lastData, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h80003000, 32'h0, 6'h05, 32'h11111111, 0, 4, 3);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h80003004, 32'h0, 6'h06, 32'h22222222, 1, 0, 1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h80003008, 32'h0, 6'h07, 32'h33333333, 0, 2, 2);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h8000300C, 32'h0, 6'h08, 32'h44444444, 0, 2, 4);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h80003010, 32'h0, 6'h09, 32'h55555555, 0, 0, 5);
    idleCycle();

    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 2));
      ad = $urandom;
      if (sz == 2'b01) ad[0] = 1'b0;
      if (sz == 2'b10) ad[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      mode = (r < 5) ? 0 : r - 4;
      dDly = $urandom_range(0, 5);
      if (mode == 3 && dDly == 0) dDly = 1;
      applyStimulus(1'($urandom), sz, 1'($urandom), ad, $urandom, 6'($urandom), $urandom,
                    $urandom_range(0, 5), dDly, mode);
      if ($urandom_range(0, 7) == 0) idleCycle();
    end

    // Reset while WAITing for data: everything must read zero afterwards.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h80004000, 32'h0, 6'h2A, 32'h0, 0, 0, 5);
    mem_issued_i = 1'b1; op_store_i = 1'b1; op_size_i = 2'b10; op_addr_i = 32'h80004000;
    op_wdata_i = 32'hCAFEF00D; op_tag_i = 6'h2A; clearExp();
    cycle();
    mem_issued_i = 1'b0; d_addr_ok_i = 1'b1;
    expWait = 1'b1; expReq = 1'b1;
    cycle();
    d_addr_ok_i = 1'b0; chkEn = 1'b0; reset_i = 1'b1;
    cycle();
    reset_i = 1'b0; chkEn = 1'b1;
    checkResetState();
    idleCycle();

    checkOutput("res_count", resCount, expCount);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
